// File: rtl/falcon_pkg.sv
// Shared constants and types for the small-polynomial sampling blocks.
package falcon_pkg;

    // Maximum coefficient bit width for f/g, indexed by LOGN.
    localparam int unsigned MAX_FG_BITS [11] = '{0, 8, 8, 8, 8, 8, 7, 7, 6, 6, 5};

    localparam int unsigned COEF_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

endpackage

// File: rtl/poly_small_collect_if.sv
// Sample input, coefficient RAM write port and status of poly_small_collect.
interface poly_small_collect_if #(
    parameter int unsigned LOGN = 9
) ();
    import falcon_pkg::*;

    logic                     start;
    logic                     val_valid;
    logic signed [31:0]       val;
    logic                     busy;
    logic                     coef_we;
    logic [LOGN-1:0]          coef_addr;
    logic [COEF_W-1:0]        coef_data;
    logic                     done;
    logic [15:0]              rej_cnt;

    modport master (
        output start, val_valid, val,
        input  busy, coef_we, coef_addr, coef_data, done, rej_cnt
    );

    modport slave (
        input  start, val_valid, val,
        output busy, coef_we, coef_addr, coef_data, done, rej_cnt
    );

endinterface

// File: rtl/poly_small_accept.sv
// Combinational acceptance test: bound check on the full sample, odd-sum check on the last one.
module poly_small_accept #(
    parameter int LIM = 32
) (
    input  logic signed [31:0] val,
    input  logic               parity,
    input  logic               last,
    output logic               accept,
    output logic               reject
);

    logic in_range;

    always_comb begin
        in_range = (val >= -LIM) && (val < LIM);
        // The final coefficient must make the coefficient sum odd.
        accept   = in_range && (!last || (parity ^ val[0]));
        reject   = !accept;
    end

endmodule

// File: rtl/poly_small_collect.sv
// Collects N accepted Gaussian samples into the coefficient RAM, counting rejections.
module poly_small_collect
    import falcon_pkg::*;
#(
    parameter int unsigned LOGN = 9,
    parameter int          LIM  = 1 << (int'(MAX_FG_BITS[LOGN]) - 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    poly_small_collect_if.slave bus
);

    state_e              state_q;
    logic [LOGN-1:0]     u_q;
    logic                parity_q;
    logic                busy_q;
    logic                we_q;
    logic [LOGN-1:0]     addr_q;
    logic [COEF_W-1:0]   data_q;
    logic                done_q;
    logic [15:0]         rej_q;

    logic last;
    logic accept;
    logic reject;

    assign last = (u_q == '1);

    poly_small_accept #(
        .LIM (LIM)
    ) u_accept (
        .val    (bus.val),
        .parity (parity_q),
        .last   (last),
        .accept (accept),
        .reject (reject)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            u_q      <= '0;
            parity_q <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            rej_q    <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q  <= StCollect;
                        u_q      <= '0;
                        parity_q <= 1'b0;
                        rej_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                StCollect: begin
                    if (bus.val_valid) begin
                        if (accept) begin
                            we_q     <= 1'b1;
                            addr_q   <= u_q;
                            data_q   <= bus.val[COEF_W-1:0];
                            parity_q <= parity_q ^ bus.val[0];
                            u_q      <= u_q + LOGN'(1);
                            if (last) state_q <= StDone;
                        end else if (reject && rej_q != 16'hFFFF) begin
                            rej_q <= rej_q + 16'd1;
                        end
                    end
                end
                StDone: begin
                    // Final write is on the bus this cycle; done follows it by one.
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.coef_we   = we_q;
    assign bus.coef_addr = addr_q;
    assign bus.coef_data = data_q;
    assign bus.done      = done_q;
    assign bus.rej_cnt   = rej_q;

endmodule

// File: tb/tb_poly_small_collect.sv
// Scoreboard bench for poly_small_collect at LOGN=9 and LOGN=10.
module tb_poly_small_collect;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    poly_small_collect_if #(.LOGN(9))  bus_a ();
    poly_small_collect_if #(.LOGN(10)) bus_b ();

    poly_small_collect #(.LOGN(9)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    poly_small_collect #(.LOGN(10)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    logic [16:0] qa [$];
    logic [17:0] qb [$];
    int exp_u_a;
    int exp_u_b;
    int done_a = 0;
    int sum_a  = 0;
    logic       prev_we_a   = 1'b0;
    logic [8:0] prev_addr_a = '0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the LOGN=9 instance.
    always @(negedge clk) begin
        logic [16:0] e;
        if (bus_a.start === 1'b1 && bus_a.busy === 1'b0) sum_a = 0;
        if (bus_a.coef_we === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_write", longint'(bus_a.coef_addr), -1);
            end else begin
                e = qa.pop_front();
                check("a_write_addr", longint'(bus_a.coef_addr), longint'(e[16:8]));
                check("a_write_data", longint'(bus_a.coef_data), longint'(e[7:0]));
            end
            sum_a += int'($signed(bus_a.coef_data));
        end
        if (bus_a.done === 1'b1) begin
            done_a++;
            check("a_done_after_last_write", longint'({prev_we_a, prev_addr_a}),
                  longint'({1'b1, 9'd511}));
            check("a_busy_low_at_done", longint'(bus_a.busy), 0);
            check("a_coef_sum_odd", longint'(sum_a & 1), 1);
        end
        prev_we_a   = bus_a.coef_we;
        prev_addr_a = bus_a.coef_addr;
    end

    // Monitor for the LOGN=10 instance, which never completes a polynomial.
    always @(negedge clk) begin
        logic [17:0] e;
        if (bus_b.coef_we === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_write", longint'(bus_b.coef_addr), -1);
            end else begin
                e = qb.pop_front();
                check("b_write_addr", longint'(bus_b.coef_addr), longint'(e[17:8]));
                check("b_write_data", longint'(bus_b.coef_data), longint'(e[7:0]));
            end
        end
        if (bus_b.done === 1'b1) check("b_unexpected_done", 1, 0);
    end

    task automatic send_a(input logic [31:0] v, input bit acc);
        bus_a.val_valid = 1'b1;
        bus_a.val       = v;
        if (acc) begin
            qa.push_back({9'(exp_u_a), v[7:0]});
            exp_u_a++;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [31:0] v, input bit acc);
        bus_b.val_valid = 1'b1;
        bus_b.val       = v;
        if (acc) begin
            qb.push_back({10'(exp_u_b), v[7:0]});
            exp_u_b++;
        end
        @(posedge clk); #1;
    endtask

    task automatic start_a();
        bus_a.val_valid = 1'b0;
        bus_a.start     = 1'b1;
        exp_u_a         = 0;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
    endtask

    task automatic wait_done_a(input int prev);
        int n = 0;
        bus_a.val_valid = 1'b0;
        while (done_a == prev && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_done_seen", done_a, prev + 1);
    endtask

    initial begin
        int prev;
        int p;
        int v;
        bus_a.start = 1'b0; bus_a.val_valid = 1'b0; bus_a.val = '0;
        bus_b.start = 1'b0; bus_b.val_valid = 1'b0; bus_b.val = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      longint'(bus_a.busy), 0);
        check("rst_coef_we",   longint'(bus_a.coef_we), 0);
        check("rst_done",      longint'(bus_a.done), 0);
        check("rst_coef_addr", longint'(bus_a.coef_addr), 0);
        check("rst_coef_data", longint'(bus_a.coef_data), 0);
        check("rst_rej_cnt",   longint'(bus_a.rej_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LOGN=10: sample coincident with start dropped, bound 16, start ignored mid-collect.
        bus_b.start = 1'b1; bus_b.val_valid = 1'b1; bus_b.val = 32'd5;
        exp_u_b = 0;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        send_b(32'd16, 1'b0);
        send_b(-32'sd16, 1'b1);
        bus_b.start = 1'b1;
        send_b(32'd3, 1'b1);
        bus_b.start = 1'b0;
        send_b(-32'sd1, 1'b1);
        bus_b.val_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b_rej_cnt", longint'(bus_b.rej_cnt), 1);
        check("b_busy", longint'(bus_b.busy), 1);
        check("b_queue_drained", qb.size(), 0);

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero first, then alternating +1/-1 ending on +1: sum is odd, nothing rejected.
        prev = done_a;
        start_a();
        send_a(32'd0, 1'b1);
        for (int i = 1; i < 512; i++) send_a((i % 2 == 1) ? 32'd1 : -32'sd1, 1'b1);
        wait_done_a(prev);
        check("t1_rej_cnt", longint'(bus_a.rej_cnt), 0);

        // Out-of-range samples, including one that only fails on the upper bits.
        prev = done_a;
        start_a();
        for (int i = 0; i < 512; i++) begin
            if (i == 100) begin
                send_a(32'd32, 1'b0);
                send_a(-32'sd33, 1'b0);
                send_a(32'h7FFF_FFFF, 1'b0);
            end
            if (i == 200)      send_a(-32'sd32, 1'b1);
            else if (i == 300) send_a(32'd31, 1'b1);
            else               send_a(32'd0, 1'b1);
        end
        wait_done_a(prev);
        check("t2_rej_cnt", longint'(bus_a.rej_cnt), 3);

        // Last coefficient must make the sum odd.
        prev = done_a;
        start_a();
        for (int i = 0; i < 511; i++) send_a(32'd0, 1'b1);
        send_a(32'd2, 1'b0);
        send_a(32'd3, 1'b1);
        wait_done_a(prev);
        check("t3_rej_cnt", longint'(bus_a.rej_cnt), 1);

        // Abort by reset after 100 writes; samples without start are ignored.
        prev = done_a;
        start_a();
        for (int i = 0; i < 100; i++) send_a(32'd0, 1'b1);
        bus_a.val_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        bus_a.val_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy",    longint'(bus_a.busy), 0);
        check("abort_coef_we", longint'(bus_a.coef_we), 0);
        check("abort_addr",    longint'(bus_a.coef_addr), 0);
        check("abort_rej_cnt", longint'(bus_a.rej_cnt), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send_a(32'd0, 1'b0);
        bus_a.val_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_a, prev);
        start_a();
        for (int i = 0; i < 511; i++) send_a(32'd0, 1'b1);
        send_a(32'd1, 1'b1);
        wait_done_a(prev);
        check("t4_rej_cnt", longint'(bus_a.rej_cnt), 0);

        // Back-to-back random in-range samples, last one forced to make the sum odd.
        prev = done_a;
        p = 0;
        start_a();
        for (int i = 0; i < 511; i++) begin
            v = int'($urandom_range(63)) - 32;
            p = p ^ (v & 1);
            send_a(32'(v), 1'b1);
        end
        v = int'($urandom_range(63)) - 32;
        if ((p ^ (v & 1)) == 0) v = v ^ 1;
        send_a(32'(v), 1'b1);
        wait_done_a(prev);
        check("t5_rej_cnt", longint'(bus_a.rej_cnt), 0);

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
